// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: byte width, receive FIFO geometry and almost-full threshold.
// Also holds the push/pop operation encoding used by the FIFO level tracking.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_WIDTH      = 8;
  localparam int UART_FIFO_ADDR_WIDTH = 4;
  localparam int UART_FIFO_DEPTH      = 1 << UART_FIFO_ADDR_WIDTH;
  localparam int UART_FIFO_AF_LEVEL   = 12;

  typedef enum logic [1:0] {
    FIFO_IDLE     = 2'b00,
    FIFO_POP      = 2'b01,
    FIFO_PUSH     = 2'b10,
    FIFO_PUSH_POP = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset; the read side is gated by empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: rx_done rising-edge detect feeding a FWFT FIFO with
// occupancy level, empty/full/almost_full flags and a sticky overrun flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = UART_FIFO_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_dout,
  input  logic                  rd,
  input  logic                  clr_ovr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overrun
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_LEVEL);

  logic                  rx_done_d;
  logic                  wr_req;
  logic                  rd_eff;
  logic                  wr_acc;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  assign empty       = (level == '0);
  assign full        = (level == DEPTH_L);
  assign almost_full = (level >= AF_L);

  assign wr_req = rx_done & ~rx_done_d;
  assign rd_eff = rd & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_acc = wr_req & (~full | rd_eff);
  assign drop   = wr_req & full & ~rd;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (rx_dout),
    .raddr (rd_ptr),
    .rdata (r_data)
  );

  // rx_done_d resets high so a receiver still showing a stale byte cannot write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_d <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun   <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_eff) rd_ptr <= rd_ptr + 1'b1;
      case (fifo_op(wr_acc, rd_eff))
        FIFO_PUSH: level <= level + 1'b1;
        FIFO_POP:  level <= level - 1'b1;
        default:   level <= level;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule
